traffic_conflict_monitor: RTL

Safety stage directly downstream of the traffic light controller. Consumes the controller's four 3-bit light buses (M1, S, MT, M2) and checks them every cycle for illegal encodings, conflicting right-of-way, illegal colour transitions and short yellows. Drives the physical lamp outputs: a one-cycle-delayed copy of the controller outputs in normal operation, or all-approach flashing red after a fault. A fault latches until an explicit clear or reset.

---
 rtl/traffic_conflict_monitor.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/traffic_conflict_monitor.sv
// ---------------------------------------------------------------------------
// traffic_conflict_monitor
//
// Safety stage that sits directly after the traffic light controller. Every
// cycle it checks the controller's four light buses for:
//   - illegal encodings,
//   - conflicting right-of-way,
//   - illegal colour transitions,
//   - yellows that end too early.
// It drives the physical lamps. In normal operation they show a one-cycle-
// delayed copy of the controller outputs. Once a fault is seen they flash red
// on every approach until clear or reset.
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  synchronous, active-high reset
//   light_M1     in   3  controller output, main road 1    {red,yellow,green}
//   light_S      in   3  controller output, side road
//   light_MT     in   3  controller output, main-road turn
//   light_M2     in   3  controller output, main road 2
//   clear        in   1  fault acknowledge, only honoured in FAULT
//   lamp_M1..M2  out  3  registered lamp drives
//   fault        out  1  registered, high while in FAULT
//   fault_code   out  3  registered first fault cause, 0 when no fault
//                        (1 encoding, 2 conflict, 3 transition, 4 short yellow)
//   dbg_state    out  2  current FSM state (0 STARTUP, 1 NORMAL, 2 FAULT)
//
// Parameters
//   STARTUP_CYC  forced all-red cycles after reset or clear (>=1)
//   MIN_YELLOW   minimum consecutive yellow cycles before red (1..15)
//   FLASH_HALF   cycles per half-period of the fault flash (>=1)
// ---------------------------------------------------------------------------
module traffic_conflict_monitor #(
    parameter int STARTUP_CYC = 4,
    parameter int MIN_YELLOW  = 3,
    parameter int FLASH_HALF  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_S,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_M2,
    input  logic       clear,
    output logic [2:0] lamp_M1,
    output logic [2:0] lamp_S,
    output logic [2:0] lamp_MT,
    output logic [2:0] lamp_M2,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] dbg_state
);

    // Colour encodings: bit2 red, bit1 yellow, bit0 green.
    localparam logic [2:0] C_RED = 3'b100;
    localparam logic [2:0] C_YEL = 3'b010;
    localparam logic [2:0] C_GRN = 3'b001;
    localparam logic [2:0] C_OFF = 3'b000;

    // Approach indices into the per-approach arrays.
    localparam int A_M1 = 0;
    localparam int A_S  = 1;
    localparam int A_MT = 2;
    localparam int A_M2 = 3;

    localparam logic [3:0] YCNT_MAX  = 4'd15;
    localparam logic [3:0] MIN_Y_CNT = 4'(MIN_YELLOW);

    // Counter widths only need to hold 0 .. N-1.
    localparam int SW = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
    localparam int FW = (FLASH_HALF  > 1) ? $clog2(FLASH_HALF)  : 1;
    localparam logic [SW-1:0] START_LAST = SW'(STARTUP_CYC - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_NORMAL  = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t          r_state;
    logic [SW-1:0]   r_start_cnt;
    logic [FW-1:0]   r_flash_cnt;
    logic            r_flash_lit;
    logic [2:0]      r_lamp [4];
    logic            r_fault;
    logic [2:0]      r_fault_code;
    logic [2:0]      r_prev [4];
    logic [3:0]      r_ycnt [4];

    // -----------------------------------------------------------------------
    // Combinational checks
    // -----------------------------------------------------------------------
    logic [2:0]      w_cur [4];
    logic [3:0]      w_active;
    logic [3:0]      w_ycnt_nxt [4];
    logic            w_not_onehot;
    logic            w_conflict;
    logic            w_illegal_tr;
    logic            w_short_yel;
    logic [2:0]      w_code;
    logic            w_hit;

    assign w_cur[A_M1] = light_M1;
    assign w_cur[A_S]  = light_S;
    assign w_cur[A_MT] = light_MT;
    assign w_cur[A_M2] = light_M2;

    always_comb begin
        w_active     = '0;
        w_not_onehot = 1'b0;
        w_illegal_tr = 1'b0;
        w_short_yel  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_ycnt_nxt[i] = 4'd0;
        end
        for (int i = 0; i < 4; i++) begin
            w_active[i] = w_cur[i][1] | w_cur[i][0];

            if (!((w_cur[i] == C_RED) || (w_cur[i] == C_YEL) || (w_cur[i] == C_GRN))) begin
                w_not_onehot = 1'b1;
            end

            // Forbidden steps: green->red, yellow->green, red->yellow.
            if (((r_prev[i] == C_GRN) && (w_cur[i] == C_RED)) ||
                ((r_prev[i] == C_YEL) && (w_cur[i] == C_GRN)) ||
                ((r_prev[i] == C_RED) && (w_cur[i] == C_YEL))) begin
                w_illegal_tr = 1'b1;
            end

            // r_ycnt holds how many yellow cycles preceded this red.
            if ((r_prev[i] == C_YEL) && (w_cur[i] == C_RED) && (r_ycnt[i] < MIN_Y_CNT)) begin
                w_short_yel = 1'b1;
            end

            if (w_cur[i] == C_YEL) begin
                if (r_prev[i] == C_YEL) begin
                    w_ycnt_nxt[i] = (r_ycnt[i] == YCNT_MAX) ? YCNT_MAX : r_ycnt[i] + 4'd1;
                end else begin
                    w_ycnt_nxt[i] = 4'd1;
                end
            end
        end
    end

    // S conflicts with everything; MT conflicts with M2. M1 may run with
    // either M2 or MT.
    assign w_conflict = (w_active[A_S] & (w_active[A_M1] | w_active[A_MT] | w_active[A_M2])) |
                        (w_active[A_MT] & w_active[A_M2]);

    // Lowest code wins when several causes coincide.
    always_comb begin
        w_code = 3'd0;
        if (w_not_onehot) begin
            w_code = 3'd1;
        end else if (w_conflict) begin
            w_code = 3'd2;
        end else if (w_illegal_tr) begin
            w_code = 3'd3;
        end else if (w_short_yel) begin
            w_code = 3'd4;
        end
    end

    assign w_hit = (w_code != 3'd0);

    // -----------------------------------------------------------------------
    // Per-approach history. It keeps following the inputs in every state,
    // FAULT included, so checks resume from true history after clear.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_prev[i] <= C_RED;
                r_ycnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_prev[i] <= w_cur[i];
                r_ycnt[i] <= w_ycnt_nxt[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Supervisor FSM with registered lamp and fault outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_STARTUP;
            r_start_cnt  <= '0;
            r_flash_cnt  <= '0;
            r_flash_lit  <= 1'b1;
            r_fault      <= 1'b0;
            r_fault_code <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_lamp[i] <= C_RED;
            end
        end else begin
            case (r_state)
                ST_STARTUP: begin
                    if (w_hit) begin
                        // A fault wins even in the last STARTUP cycle.
                        r_state      <= ST_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_code;
                        r_flash_cnt  <= '0;
                        r_flash_lit  <= 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            r_lamp[i] <= C_RED;
                        end
                    end else if (r_start_cnt == START_LAST) begin
                        // The first NORMAL cycle shows this cycle's inputs.
                        r_state <= ST_NORMAL;
                        for (int i = 0; i < 4; i++) begin
                            r_lamp[i] <= w_cur[i];
                        end
                    end else begin
                        r_start_cnt <= r_start_cnt + 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            r_lamp[i] <= C_RED;
                        end
                    end
                end

                ST_NORMAL: begin
                    if (w_hit) begin
                        // The offending inputs are never copied to a lamp.
                        r_state      <= ST_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_code;
                        r_flash_cnt  <= '0;
                        r_flash_lit  <= 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            r_lamp[i] <= C_RED;
                        end
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            r_lamp[i] <= w_cur[i];
                        end
                    end
                end

                ST_FAULT: begin
                    if (clear) begin
                        r_state      <= ST_STARTUP;
                        r_fault      <= 1'b0;
                        r_fault_code <= 3'd0;
                        r_start_cnt  <= '0;
                        for (int i = 0; i < 4; i++) begin
                            r_lamp[i] <= C_RED;
                        end
                    end else if (r_flash_cnt == FLASH_LAST) begin
                        // End of a half-period: flip the phase.
                        r_flash_cnt <= '0;
                        r_flash_lit <= ~r_flash_lit;
                        for (int i = 0; i < 4; i++) begin
                            r_lamp[i] <= r_flash_lit ? C_OFF : C_RED;
                        end
                    end else begin
                        r_flash_cnt <= r_flash_cnt + 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            r_lamp[i] <= r_flash_lit ? C_RED : C_OFF;
                        end
                    end
                end

                default: begin
                    // Recover to the safe state from an undefined encoding.
                    r_state      <= ST_STARTUP;
                    r_start_cnt  <= '0;
                    r_fault      <= 1'b0;
                    r_fault_code <= 3'd0;
                    for (int i = 0; i < 4; i++) begin
                        r_lamp[i] <= C_RED;
                    end
                end
            endcase
        end
    end

    assign lamp_M1    = r_lamp[A_M1];
    assign lamp_S     = r_lamp[A_S];
    assign lamp_MT    = r_lamp[A_MT];
    assign lamp_M2    = r_lamp[A_M2];
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign dbg_state  = r_state;

endmodule
